// File: rtl/mux_xfer_sched.sv
// ============================================================================
//  Module      : mux_xfer_sched
//  Description : Arbitrated mux-based transfer scheduler feeding a CDC capture
//                stage. Grants one requester at a time, presents its data with
//                data_en high for HOLD_CYC cycles, then holds the data stable
//                for GAP_CYC guard cycles before accepting a new request.
//                Default arbitration is round-robin; defining
//                MUX_SCHED_FIXED_PRI_EN selects fixed priority (lowest index).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_xfer_sched #(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 3
) (
    input  logic                                         clk_a,
    input  logic                                         arstn,
    input  logic [NREQ-1:0]                              req,
    input  logic [NREQ*DW-1:0]                           req_data,
    output logic [DW-1:0]                                data_in,
    output logic                                         data_en,
    output logic [NREQ-1:0]                              done,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]   gnt_id,
    output logic                                         busy
);

    // Widths: requester index, and a phase counter that covers the longer phase
    localparam int c_id_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_cnt_max = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int c_cnt_w = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // State and registered outputs
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DW-1:0]        r_data;
    logic                 r_en;
    logic [NREQ-1:0]      r_done;
    logic [c_id_w-1:0]    r_gnt;
    logic                 r_busy;

    // Next-state values
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [DW-1:0]        w_data_nxt;
    logic                 w_en_nxt;
    logic [NREQ-1:0]      w_done_nxt;
    logic [c_id_w-1:0]    w_gnt_nxt;
    logic                 w_busy_nxt;

    // Arbiter result
    logic                 w_win_valid;
    logic [c_id_w-1:0]    w_win_id;

    // Per-requester data slices
    logic [DW-1:0]        w_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_slice[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

`ifdef MUX_SCHED_FIXED_PRI_EN
    // Fixed priority: lowest set request index wins
    always_comb begin : p_arb
        w_win_valid = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_win_valid && req[c_id_w'(k)]) begin
                w_win_valid = 1'b1;
                w_win_id    = c_id_w'(k);
            end
        end
    end
`else
    logic [c_id_w-1:0]    r_last;
    logic                 w_grant;

    // Round-robin: search starts one past the last winner, first set bit wins
    always_comb begin : p_arb
        int idx;
        idx         = 0;
        w_win_valid = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_last) + 1 + k) % NREQ;
            if (!w_win_valid && req[c_id_w'(idx)]) begin
                w_win_valid = 1'b1;
                w_win_id    = c_id_w'(idx);
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_win_valid;

    // Last-winner pointer moves only when a grant is issued
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            r_last <= c_id_w'(NREQ - 1);
        end else if (w_grant) begin
            r_last <= w_win_id;
        end
    end
`endif

    // Next-state and next-output decode; outputs are derived from the next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = w_slice[w_win_id];
                    w_gnt_nxt   = w_win_id;
                end
            end
            S_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt       = S_GAP;
                    w_cnt_nxt         = '0;
                    w_done_nxt[r_gnt] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_en_nxt   = (w_state_nxt == S_HOLD);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_done  <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign data_in = r_data;
    assign data_en = r_en;
    assign done    = r_done;
    assign gnt_id  = r_gnt;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux_xfer_sched.sv
// ============================================================================
//  Module      : tb_mux_xfer_sched
//  Description : Directed self-checking bench for mux_xfer_sched. A default
//                instance (HOLD 4 / GAP 3) and a fast instance (HOLD 1 / GAP 1)
//                share clock and reset. Expectations for arbitration order
//                follow MUX_SCHED_FIXED_PRI_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_xfer_sched;

    logic        clk_a = 1'b0;
    logic        arstn = 1'b1;

    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  data_in;
    logic        data_en;
    logic [3:0]  done;
    logic [1:0]  gnt_id;
    logic        busy;

    logic [3:0]  req_f;
    logic [15:0] req_data_f;
    logic [3:0]  data_in_f;
    logic        data_en_f;
    logic [3:0]  done_f;
    logic [1:0]  gnt_id_f;
    logic        busy_f;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_xfer_sched #(.NREQ(4), .DW(4), .HOLD_CYC(4), .GAP_CYC(3)) u_dut (
        .clk_a    (clk_a),
        .arstn    (arstn),
        .req      (req),
        .req_data (req_data),
        .data_in  (data_in),
        .data_en  (data_en),
        .done     (done),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    mux_xfer_sched #(.NREQ(4), .DW(4), .HOLD_CYC(1), .GAP_CYC(1)) u_dut_fast (
        .clk_a    (clk_a),
        .arstn    (arstn),
        .req      (req_f),
        .req_data (req_data_f),
        .data_in  (data_in_f),
        .data_en  (data_en_f),
        .done     (done_f),
        .gnt_id   (gnt_id_f),
        .busy     (busy_f)
    );

    always #5 clk_a = ~clk_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_a);
        arstn = 1'b0;
        req   = '0;
        req_f = '0;
        @(negedge clk_a);
        @(negedge clk_a);
        arstn = 1'b1;
    endtask

    initial begin
        logic [3:0] oh;
        logic       prev_en;
        int         rises;
        int         g;
        int         ph;
        int         n;

        req        = '0;
        req_data   = '0;
        req_f      = '0;
        req_data_f = '0;

        // Reset state
        #2 arstn = 1'b0;
        @(negedge clk_a);
        check("rst_data_in", 32'(data_in), 32'h0);
        check("rst_data_en", 32'(data_en), 32'h0);
        check("rst_done",    32'(done),    32'h0);
        check("rst_gnt_id",  32'(gnt_id),  32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        @(negedge clk_a);
        arstn = 1'b1;

        // Single request from requester 2 with data A
        req      = 4'b0100;
        req_data = 16'h0A00;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_a);
            check("single_en",   32'(data_en), 32'((c >= 1 && c <= 4) ? 1 : 0));
            check("single_data", 32'(data_in), 32'hA);
            check("single_done", 32'(done),    32'((c == 5) ? 4'b0100 : 4'b0000));
            check("single_busy", 32'(busy),    32'((c <= 7) ? 1 : 0));
            if (c <= 7) check("single_gnt", 32'(gnt_id), 32'd2);
            if (c == 5) req = 4'b0000;
        end

        // All four requesting continuously
        do_reset();
        req      = 4'b1111;
        req_data = 16'h4321;
        prev_en  = 1'b0;
        rises    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_a);
            ph = (c - 1) % 8;
            n  = (c - 1) / 8;
`ifdef MUX_SCHED_FIXED_PRI_EN
            g = 0;
`else
            g = n % 4;
`endif
            oh = 4'b0001 << g;
            check("rr_en",   32'(data_en), 32'((ph < 4) ? 1 : 0));
            check("rr_done", 32'(done),    32'((ph == 4) ? oh : 4'b0000));
            if (ph < 5) begin
                check("rr_gnt",  32'(gnt_id),  32'(g));
                check("rr_data", 32'(data_in), 32'(g + 1));
            end
            if (data_en && !prev_en) begin
                check("rr_rise_cycle", 32'(c), 32'(1 + 8 * rises));
                rises++;
            end
            prev_en = data_en;
            if (c == 40) req = 4'b0000;
        end
        check("rr_rise_count", 32'(rises), 32'd5);

        // Requesters 0 and 1 continuously; last winner is 0 at this point
        req      = 4'b0011;
        req_data = 16'h00BA;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk_a);
            ph = (c - 1) % 8;
            n  = (c - 1) / 8;
`ifdef MUX_SCHED_FIXED_PRI_EN
            g = 0;
`else
            g = (n % 2 == 0) ? 1 : 0;
`endif
            oh = 4'b0001 << g;
            check("pair_en",   32'(data_en), 32'((ph < 4) ? 1 : 0));
            check("pair_done", 32'(done),    32'((ph == 4) ? oh : 4'b0000));
            if (ph == 0) begin
                check("pair_gnt",  32'(gnt_id),  32'(g));
                check("pair_data", 32'(data_in), 32'((g == 0) ? 4'hA : 4'hB));
            end
            if (c == 24) req = 4'b0000;
        end

        // Owner drops request and rewrites data during HOLD
        req      = 4'b0010;
        req_data = 16'h0050;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_a);
            check("chg_data", 32'(data_in), 32'h5);
            check("chg_en",   32'(data_en), 32'((c <= 4) ? 1 : 0));
            check("chg_done", 32'(done),    32'((c == 5) ? 4'b0010 : 4'b0000));
            check("chg_busy", 32'(busy),    32'((c <= 7) ? 1 : 0));
            if (c <= 7) check("chg_gnt", 32'(gnt_id), 32'd1);
            if (c == 2) begin
                req      = 4'b0000;
                req_data = 16'h00F0;
            end
        end

        // Reset asserted during the second HOLD cycle
        req      = 4'b1000;
        req_data = 16'h7000;
        @(negedge clk_a);
        check("abort_gnt1", 32'(gnt_id), 32'd3);
        @(negedge clk_a);
        check("abort_en2", 32'(data_en), 32'h1);
        arstn = 1'b0;
        #1;
        check("abort_data_in", 32'(data_in), 32'h0);
        check("abort_data_en", 32'(data_en), 32'h0);
        check("abort_done",    32'(done),    32'h0);
        check("abort_gnt_id",  32'(gnt_id),  32'h0);
        check("abort_busy",    32'(busy),    32'h0);
        req      = 4'b1010;
        req_data = 16'h9080;
        @(negedge clk_a);
        check("abort_hold_done", 32'(done), 32'h0);
        arstn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_a);
            check("post_en",   32'(data_en), 32'((c <= 4) ? 1 : 0));
            check("post_done", 32'(done),    32'((c == 5) ? 4'b0010 : 4'b0000));
            if (c <= 5) begin
                check("post_gnt",  32'(gnt_id),  32'd1);
                check("post_data", 32'(data_in), 32'h8);
            end
            if (c == 5) req = 4'b0000;
        end

        // HOLD 1 / GAP 1 instance under continuous request
        req_f      = 4'b0001;
        req_data_f = 16'h000C;
        prev_en    = 1'b0;
        rises      = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_a);
            ph = (c - 1) % 3;
            check("fast_en",   32'(data_en_f), 32'((ph == 0) ? 1 : 0));
            check("fast_done", 32'(done_f),    32'((ph == 1) ? 4'b0001 : 4'b0000));
            check("fast_busy", 32'(busy_f),    32'((ph != 2) ? 1 : 0));
            check("fast_data", 32'(data_in_f), 32'hC);
            check("fast_gnt",  32'(gnt_id_f),  32'h0);
            if (data_en_f && !prev_en) begin
                check("fast_rise_cycle", 32'(c), 32'(1 + 3 * rises));
                rises++;
            end
            prev_en = data_en_f;
        end
        req_f = 4'b0000;
        check("fast_rise_count", 32'(rises), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_xfer_sched.md
MUX_XFER_SCHED -- requirements
Module: mux_xfer_sched

Interface
REQ-001 The block SHALL have the following parameters:
- NREQ, default 4: number of requesters.
- DW, default 4: data width.
- HOLD_CYC, default 4, minimum 1: data_en high time, in cycles.
- GAP_CYC, default 3, minimum 1: post-transfer stable/guard time, in cycles.
REQ-002 The block SHALL have the following ports (clock and reset first):
- clk_a, input, 1: the single clock; all logic is rising-edge.
- arstn, input, 1: reset, asynchronous, active-low.
- req, input, NREQ: per-requester transfer request, level.
- req_data, input, NREQ*DW: requester i data in slice [i*DW +: DW].
- data_in, output, DW: registered data to the CDC capture stage.
- data_en, output, 1: registered enable to the CDC capture stage.
- done, output, NREQ: one-hot, one-cycle transfer-complete pulse.
- gnt_id, output, clog2(NREQ): index of the current owner; valid while busy.
- busy, output, 1: high when the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, HOLD and GAP; all outputs SHALL be registered.
REQ-004 IDLE SHALL evaluate req every cycle; if req is nonzero in cycle T, then at T+1:
- state = HOLD;
- data_in = winner's req_data slice (sampled at T);
- data_en = 1;
- gnt_id = winner;
- busy = 1.
REQ-005 If req is zero, IDLE SHALL keep data_en=0 and SHALL hold data_in at its previous value.
REQ-006 Arbitration SHALL be round-robin: the search starts at (last_winner+1) mod NREQ and takes the first set bit; last_winner updates only on grant.
REQ-007 HOLD SHALL last exactly HOLD_CYC cycles with data_en=1, and data_in and gnt_id SHALL remain constant.
REQ-008 On the cycle after the last HOLD cycle: state = GAP, data_en = 0, and done[gnt_id] = 1 for exactly that one cycle.
REQ-009 GAP SHALL last exactly GAP_CYC cycles with data_in held; after the final GAP cycle, state = IDLE and busy = 0.
REQ-010 A new grant SHALL NOT occur before the block returns to IDLE; minimum spacing between data_en rising edges = HOLD_CYC+GAP_CYC+1 cycles.
REQ-011 req and req_data changes during HOLD/GAP SHALL NOT affect the transfer in flight; if the owner deasserts req mid-transfer, the transfer still completes and done still pulses.
REQ-012 A requester SHALL hold req and req_data stable until it sees done; if req is still high in IDLE, it is a new request.
REQ-013 A single continuous requester SHALL be granted back-to-back, with one IDLE cycle between transfers.
REQ-014 Counters SHALL be sized for the larger of HOLD_CYC and GAP_CYC and SHALL NOT wrap.
REQ-015 done SHALL be zero in every cycle except the HOLD-to-GAP transition cycle.

Reset
REQ-016 arstn low SHALL immediately force:
- state = IDLE;
- data_in = 0, data_en = 0, done = 0, gnt_id = 0, busy = 0;
- counters = 0;
- last_winner = NREQ-1, so that requester 0 has first priority.
REQ-017 Reset asserted mid-HOLD or mid-GAP SHALL abort the transfer with no done pulse; the first grant after release SHALL follow REQ-016 priority.
REQ-018 Deassertion of arstn SHALL take effect on the next clk_a edge.

Configuration
REQ-019 When macro MUX_SCHED_FIXED_PRI_EN is defined, arbitration SHALL be fixed priority (lowest index wins) and last_winner SHALL be removed.
REQ-020 When MUX_SCHED_FIXED_PRI_EN is undefined, arbitration SHALL be round-robin per REQ-006; all other behaviour SHALL be identical in both builds.

Verification
REQ-021 Single request, defaults: req=4'b0100 with slice 2 = 4'hA at cycle 0 -> the bench SHALL check:
- cycles 1-4: data_en=1, data_in=A, gnt_id=2;
- cycle 5: done=4'b0100, data_en=0;
- cycle 8: busy=0.
REQ-022 Round-robin fairness: req=4'b1111 held constant -> grant order 0,1,2,3,0; each data_en rising edge 8 cycles apart.
REQ-023 Mid-transfer change: owner drops req and rewrites its data during HOLD -> data_in stays at the original value through GAP, and done still pulses.
REQ-024 Reset abort: arstn pulsed low in HOLD cycle 2 -> all outputs 0 at once, no done pulse; with req=4'b1010 after release, requester 1 wins first.
REQ-025 Fixed-priority build (MUX_SCHED_FIXED_PRI_EN defined): req=4'b0011 held constant -> requester 0 is granted every transfer, and requester 1 is never granted.
REQ-026 Parameter corner: HOLD_CYC=1 and GAP_CYC=1 -> data_en high for 1 cycle, done on the next cycle, and a data_en rising edge every 3 cycles under continuous request.
